// File: rtl/sys_arr_pkg.sv
// Purpose: shared widths and FSM encodings for the systolic-array result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_arr_pkg;

   localparam int DATA_W = 8;    // array operand width
   localparam int SUM_W  = 16;   // per-column accumulated sum width

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/sys_arr_delay_line.sv
// Purpose: fixed-length register delay for one array column (data plus active bit).
// Latency: depth cycles; depth 0 is a plain wire.
// Backpressure: none, free-running shift register.
//
// Ports: clk, reset (sync, active-high), din -> dout delayed by depth cycles.
module sys_arr_delay_line #(
   parameter int depth = 0,
   parameter int width = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);

   if (depth == 0) begin : g_wire
      // Clock and reset have no load on the zero-depth column.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign dout = din;
   end else begin : g_regs
      logic [width-1:0] stage_q [depth];
      logic [width-1:0] stage_d [depth];

      always_comb begin
         stage_d[0] = din;
         for (int i = 1; i < depth; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < depth; i++) begin
               stage_q[i] <= '0;
            end
         end else begin
            stage_q <= stage_d;
         end
      end

      assign dout = stage_q[depth-1];
   end

endmodule

// File: rtl/sys_arr_collector.sv
// Purpose: de-skews systolic-array bottom-row sums into whole rows and buffers them in a FIFO.
// Latency: row_valid earliest 2 cycles after the last column's active bit is sampled.
// Backpressure: row_valid/row_ready; rows arriving to a full FIFO are dropped and flagged.
//
// Ports: clk, reset (sync, active-high); start/num_rows launch a job; maccin/activein are the
// skewed array outputs; row_data/row_valid/row_ready is the row stream; busy, done (pulse),
// overflow (sticky drop) and misalign (sticky skew error) report status.
module sys_arr_collector
   import sys_arr_pkg::*;
#(
   parameter int width_height = 2,
   parameter int fifo_depth   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [7:0]                    num_rows,
   input  logic [SUM_W*width_height-1:0] maccin,
   input  logic [width_height-1:0]       activein,
   output logic [SUM_W*width_height-1:0] row_data,
   output logic                          row_valid,
   input  logic                          row_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   output logic                          misalign
);

   localparam int ROW_W = SUM_W * width_height;
   localparam int PTR_W = $clog2(fifo_depth);
   localparam int CNT_W = $clog2(fifo_depth + 1);
   localparam int QW    = $clog2(width_height + 1);

   // ---------------- per-column de-skew ----------------
   logic [ROW_W-1:0]        dly_sum;
   logic [width_height-1:0] dly_act;

   for (genvar c = 0; c < width_height; c++) begin : g_col
      logic [SUM_W:0] col_out;
      sys_arr_delay_line #(
         .depth (width_height - 1 - c),
         .width (SUM_W + 1)
      ) u_dly (
         .clk   (clk),
         .reset (reset),
         .din   ({activein[c], maccin[c*SUM_W +: SUM_W]}),
         .dout  (col_out)
      );
      assign dly_act[c]                 = col_out[SUM_W];
      assign dly_sum[c*SUM_W +: SUM_W]  = col_out[SUM_W-1:0];
   end

   // ---------------- state ----------------
   state_e                  state_q, state_d;
   logic [7:0]              num_rows_q, num_rows_d;
   logic [7:0]              rows_seen_q, rows_seen_d;
   logic [ROW_W-1:0]        aligned_sum_q, aligned_sum_d;
   logic [width_height-1:0] aligned_act_q, aligned_act_d;
   logic [ROW_W-1:0]        mem_q [fifo_depth];
   logic [ROW_W-1:0]        mem_d [fifo_depth];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [QW-1:0]           quiet_q, quiet_d;
   logic                    overflow_q, overflow_d;
   logic                    misalign_q, misalign_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    row_valid_q, row_valid_d;

   logic row_formed, partial_row, full, pop, push, drop, start_acc, in_collect, pipe_empty;

   always_comb begin
      row_formed  = &aligned_act_q;
      partial_row = (|aligned_act_q) && !row_formed;
      full        = (count_q == CNT_W'(fifo_depth));
      pop         = (count_q != '0) && row_ready;
      in_collect  = (state_q == ST_COLLECT);
      start_acc   = (state_q == ST_IDLE) && start;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push        = row_formed && in_collect && (!full || pop);
      drop        = row_formed && in_collect && full && !pop;
      // Activity takes up to width_height cycles to leave the delay lines and aligned register.
      pipe_empty  = (quiet_q == QW'(width_height));

      aligned_sum_d = dly_sum;
      aligned_act_d = dly_act;

      num_rows_d  = start_acc ? num_rows : num_rows_q;
      rows_seen_d = rows_seen_q;
      if (start_acc) begin
         rows_seen_d = '0;
      end else if (row_formed && in_collect) begin
         rows_seen_d = rows_seen_q + 8'd1;
      end

      overflow_d = overflow_q;
      misalign_d = misalign_q;
      if (start_acc) begin
         overflow_d = 1'b0;
         misalign_d = 1'b0;
      end else begin
         if (drop)        overflow_d = 1'b1;
         if (partial_row) misalign_d = 1'b1;
      end

      quiet_d = quiet_q;
      if (|activein) begin
         quiet_d = '0;
      end else if (!pipe_empty) begin
         quiet_d = quiet_q + QW'(1);
      end

      // FIFO
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = aligned_sum_q;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end

      // FSM
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = (num_rows == 8'd0) ? ST_DONE : ST_COLLECT;
         ST_COLLECT: if (rows_seen_d == num_rows_q) state_d = ST_DRAIN;
         ST_DRAIN:   if ((count_q == '0) && pipe_empty) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      busy_d      = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
      done_d      = (state_d == ST_DONE);
      row_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         num_rows_q    <= '0;
         rows_seen_q   <= '0;
         aligned_sum_q <= '0;
         aligned_act_q <= '0;
         for (int i = 0; i < fifo_depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         quiet_q       <= QW'(width_height);
         overflow_q    <= 1'b0;
         misalign_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         row_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_rows_q    <= num_rows_d;
         rows_seen_q   <= rows_seen_d;
         aligned_sum_q <= aligned_sum_d;
         aligned_act_q <= aligned_act_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         quiet_q       <= quiet_d;
         overflow_q    <= overflow_d;
         misalign_q    <= misalign_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         row_valid_q   <= row_valid_d;
      end
   end

   // Head entry only changes on a pop, so row_data holds while stalled.
   assign row_data  = row_valid_q ? mem_q[rd_ptr_q] : '0;
   assign row_valid = row_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_sys_arr_collector.sv
module tb_sys_arr_collector;
   import sys_arr_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  num_rows = 8'd0;
   logic [31:0] maccin = '0;
   logic [1:0]  activein = '0;
   logic [31:0] row_data;
   logic        row_valid;
   logic        row_ready = 1'b0;
   logic        busy, done, overflow, misalign;

   int total = 0;
   int bad   = 0;

   sys_arr_collector #(.width_height(2), .fifo_depth(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_rows  (num_rows),
      .maccin    (maccin),
      .activein  (activein),
      .row_data  (row_data),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .misalign  (misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] col0_of(input int k);
      return 16'(17 * (k + 1));
   endfunction

   function automatic logic [15:0] col1_of(input int k);
      return 16'(170 + 17 * k);
   endfunction

   function automatic logic [31:0] row_of(input int k);
      return {col1_of(k), col0_of(k)};
   endfunction

   task automatic start_job(input logic [7:0] n);
      start    = 1'b1;
      num_rows = n;
      tick();
      start    = 1'b0;
   endtask

   // Streams n well-skewed rows (column 1 one cycle behind column 0) over n+2 cycles.
   task automatic send_rows(input int n, input int first, input logic rdy_base, input int pop_at);
      for (int i = 0; i <= n + 1; i++) begin
         activein[0]   = (i < n);
         maccin[15:0]  = (i < n) ? col0_of(first + i) : 16'h0;
         activein[1]   = (i >= 1 && i <= n);
         maccin[31:16] = (i >= 1 && i <= n) ? col1_of(first + i - 1) : 16'h0;
         row_ready     = (i == pop_at) ? ~rdy_base : rdy_base;
         tick();
      end
      row_ready = rdy_base;
   endtask

   task automatic drain_check(input string tag, input int n, input int first);
      row_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         check({tag, "_valid"}, row_valid, 1'b1);
         check({tag, "_data"}, row_data, row_of(first + k));
         tick();
      end
      row_ready = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (done) seen = 1'b1;
         else tick();
      end
      check(tag, seen, 1'b1);
      tick();
      check({tag, "_idle"}, dut.state_q, ST_IDLE);
   endtask

   initial begin
      // ---- reset ----
      tick();
      tick();
      check("rst_valid", row_valid, 1'b0);
      check("rst_data", row_data, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_flags", {overflow, misalign}, 2'b00);
      reset = 1'b0;
      tick();
      check("rst_state", dut.state_q, ST_IDLE);

      // ---- basic two-row job, checked cycle by cycle ----
      row_ready = 1'b1;
      start_job(8'd2);
      check("b_busy", busy, 1'b1);
      activein = 2'b01; maccin = 32'h0000_0011;          // cycle t
      tick();
      activein = 2'b11; maccin = 32'h00AA_0022;          // cycle t+1
      tick();
      activein = 2'b10; maccin = 32'h00BB_0000;          // cycle t+2
      check("b_no_valid_t2", row_valid, 1'b0);
      tick();
      activein = 2'b00; maccin = 32'h0;                  // cycle t+3
      check("b_valid_t3", row_valid, 1'b1);
      check("b_row0", row_data, 32'h00AA_0011);
      tick();                                            // cycle t+4
      check("b_row1", row_data, 32'h00BB_0022);
      check("b_busy_drain", busy, 1'b1);
      tick();                                            // cycle t+5
      check("b_empty", row_valid, 1'b0);
      check("b_no_done_yet", done, 1'b0);
      tick();                                            // cycle t+6
      check("b_done", done, 1'b1);
      check("b_busy_off", busy, 1'b0);
      tick();
      check("b_done_pulse", done, 1'b0);

      // ---- zero-row job ----
      start_job(8'd0);
      check("z_done", done, 1'b1);
      check("z_busy", busy, 1'b0);
      tick();
      check("z_done_off", done, 1'b0);
      check("z_busy_off", busy, 1'b0);

      // ---- skew error ----
      start_job(8'd1);
      activein = 2'b11; maccin = 32'h1234_5678;
      tick();
      activein = 2'b00; maccin = 32'h0;
      tick();
      tick();
      tick();
      check("m_misalign", misalign, 1'b1);
      check("m_rows_seen", dut.rows_seen_q, 8'd0);
      check("m_no_push", row_valid, 1'b0);
      check("m_busy", busy, 1'b1);
      send_rows(1, 0, 1'b1, -1);
      wait_done("m_done");
      check("m_sticky", misalign, 1'b1);

      // ---- overflow with stalled consumer ----
      row_ready = 1'b0;
      start_job(8'd6);
      check("o_clear_misalign", misalign, 1'b0);
      send_rows(6, 0, 1'b0, -1);
      tick();
      check("o_count", dut.count_q, 3'd4);
      check("o_overflow", overflow, 1'b1);
      check("o_rows_seen", dut.rows_seen_q, 8'd6);
      check("o_state", dut.state_q, ST_DRAIN);
      check("o_hold", row_data, row_of(0));
      drain_check("o_drain", 4, 0);
      check("o_empty", row_valid, 1'b0);
      wait_done("o_done");

      // ---- push and pop together while full ----
      start_job(8'd5);
      check("f_clear_overflow", overflow, 1'b0);
      send_rows(5, 0, 1'b0, 6);
      check("f_count", dut.count_q, 3'd4);
      check("f_overflow", overflow, 1'b0);
      drain_check("f_drain", 4, 1);
      wait_done("f_done");

      // ---- reset in the middle of a job ----
      start_job(8'd4);
      send_rows(2, 0, 1'b0, -1);
      check("r_count", dut.count_q, 3'd2);
      check("r_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      check("r_valid", row_valid, 1'b0);
      check("r_busy_off", busy, 1'b0);
      check("r_done", done, 1'b0);
      reset = 1'b0;
      tick();
      check("r_no_done", done, 1'b0);
      check("r_idle", dut.state_q, ST_IDLE);
      start_job(8'd2);
      send_rows(2, 3, 1'b0, -1);
      drain_check("r_after", 2, 3);
      wait_done("r_after_done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
